// File: rtl/axis_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module   : axis_traffic_gen
//  Brief    : NoC injector emitting single-beat AXI-Stream packets to random
//             destinations at a programmable rate. Optional stall counter is
//             built when AXIS_GEN_STALL_COUNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_traffic_gen #(
    parameter int          COUNT_WIDTH = 32,
    parameter int          TID         = 0,
    parameter int          TDATA_WIDTH = 512,
    parameter int          TDEST_WIDTH = 2,
    parameter int          TID_WIDTH   = 2,
    parameter int          NUM_ROUTERS = 2,
    parameter int          INJ_RATE    = 256,
    parameter logic [15:0] SEED        = 16'hACE1 ^ 16'(TID)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [TDATA_WIDTH/2-1:0] ticks,
    input  logic                     enable,
    input  logic [COUNT_WIDTH-1:0]   num_packets,
    output logic [COUNT_WIDTH-1:0]   sent_packets [NUM_ROUTERS],
    output logic [COUNT_WIDTH-1:0]   total_sent_packets,
    output logic                     done,
    output logic [COUNT_WIDTH-1:0]   stall_cycles,
    output logic                     axis_out_tvalid,
    input  logic                     axis_out_tready,
    output logic [TDATA_WIDTH-1:0]   axis_out_tdata,
    output logic                     axis_out_tlast,
    output logic [TID_WIDTH-1:0]     axis_out_tid,
    output logic [TDEST_WIDTH-1:0]   axis_out_tdest
);

    localparam int                     c_HALF     = TDATA_WIDTH / 2;
    localparam logic [15:0]            c_TAPS     = 16'hB400;
    localparam logic [8:0]             c_RATE     = 9'(INJ_RATE);
    localparam logic [8:0]             c_NUM_DEST = 9'(NUM_ROUTERS);
    localparam logic [COUNT_WIDTH-1:0] c_ONE      = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [15:0]            r_lfsr;
    logic [COUNT_WIDTH-1:0] r_remaining;

    logic                   w_inject;
    logic                   w_fire;
    logic [TDEST_WIDTH-1:0] w_dest;
    logic [COUNT_WIDTH-1:0] w_seq;

    assign w_inject = {1'b0, r_lfsr[7:0]} < c_RATE;
    assign w_dest   = TDEST_WIDTH'({1'b0, r_lfsr[15:8]} % c_NUM_DEST);
    assign w_fire   = axis_out_tvalid & axis_out_tready;

    // Sequence number for a new beat must see the increment of a beat
    // retiring to the same destination in this very cycle.
    always_comb begin
        w_seq = '0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (w_dest == TDEST_WIDTH'(i)) begin
                w_seq = sent_packets[i];
            end
        end
        if (w_fire && (w_dest == axis_out_tdest)) begin
            w_seq = w_seq + c_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ c_TAPS) : (r_lfsr >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_remaining        <= '0;
            total_sent_packets <= '0;
            done               <= 1'b0;
            axis_out_tvalid    <= 1'b0;
            axis_out_tdata     <= '0;
            axis_out_tdest     <= '0;
            axis_out_tid       <= '0;
            axis_out_tlast     <= 1'b1;
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                sent_packets[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_remaining <= num_packets;
                        if (num_packets == '0) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_GEN;
                        end
                    end
                end

                S_GEN: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_inject) begin
                        axis_out_tdata  <= {ticks, c_HALF'(w_seq)};
                        axis_out_tdest  <= w_dest;
                        axis_out_tid    <= TID_WIDTH'(TID);
                        axis_out_tlast  <= 1'b1;
                        axis_out_tvalid <= 1'b1;
                        r_state         <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // Beat is never withdrawn; enable only matters once it retires.
                    if (w_fire) begin
                        for (int i = 0; i < NUM_ROUTERS; i++) begin
                            if (axis_out_tdest == TDEST_WIDTH'(i)) begin
                                sent_packets[i] <= sent_packets[i] + c_ONE;
                            end
                        end
                        total_sent_packets <= total_sent_packets + c_ONE;
                        r_remaining        <= r_remaining - c_ONE;
                        if (r_remaining == c_ONE) begin
                            axis_out_tvalid <= 1'b0;
                            done            <= 1'b1;
                            r_state         <= S_DONE;
                        end else if (enable && w_inject) begin
                            axis_out_tdata  <= {ticks, c_HALF'(w_seq)};
                            axis_out_tdest  <= w_dest;
                            axis_out_tid    <= TID_WIDTH'(TID);
                            axis_out_tlast  <= 1'b1;
                            axis_out_tvalid <= 1'b1;
                        end else if (enable) begin
                            axis_out_tvalid <= 1'b0;
                            r_state         <= S_GEN;
                        end else begin
                            axis_out_tvalid <= 1'b0;
                            r_state         <= S_IDLE;
                        end
                    end
                end

                S_DONE: begin
                    if (!enable) begin
                        done    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_GEN_STALL_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (axis_out_tvalid && !axis_out_tready) begin
            r_stall <= r_stall + c_ONE;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_traffic_gen
//  Brief    : Self-checking bench for axis_traffic_gen (rate 256 and rate 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_traffic_gen;

    localparam int          CW     = 16;
    localparam int          TDW    = 64;
    localparam int          HW     = TDW / 2;
    localparam int          DW     = 2;
    localparam int          IW     = 2;
    localparam int          NR     = 4;
    localparam int          MY_TID = 1;
    localparam logic [15:0] MY_SEED = 16'hACE1 ^ 16'd1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [HW-1:0] ticks;
    logic          enable, tready;
    logic [CW-1:0] num_packets;
    logic [CW-1:0] sent [NR];
    logic [CW-1:0] total_sent, stall;
    logic          done, tvalid, tlast;
    logic [TDW-1:0] tdata;
    logic [IW-1:0]  tid;
    logic [DW-1:0]  tdest;

    logic          z_enable, z_tready;
    logic [CW-1:0] z_num;
    logic [CW-1:0] z_sent [NR];
    logic [CW-1:0] z_total, z_stall;
    logic          z_done, z_tvalid, z_tlast;
    logic [TDW-1:0] z_tdata;
    logic [IW-1:0]  z_tid;
    logic [DW-1:0]  z_tdest;

    int n_checks = 0;
    int n_bad    = 0;
    int q[$];
    logic [15:0] lfsr_tab [8192];

    always #5 clk = ~clk;

    // Free-running timestamp: equals the number of clock edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ticks <= '0;
        else        ticks <= ticks + 1'b1;
    end

    axis_traffic_gen #(
        .COUNT_WIDTH(CW), .TID(MY_TID), .TDATA_WIDTH(TDW), .TDEST_WIDTH(DW),
        .TID_WIDTH(IW), .NUM_ROUTERS(NR), .INJ_RATE(256)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ticks(ticks), .enable(enable),
        .num_packets(num_packets), .sent_packets(sent),
        .total_sent_packets(total_sent), .done(done), .stall_cycles(stall),
        .axis_out_tvalid(tvalid), .axis_out_tready(tready),
        .axis_out_tdata(tdata), .axis_out_tlast(tlast),
        .axis_out_tid(tid), .axis_out_tdest(tdest)
    );

    axis_traffic_gen #(
        .COUNT_WIDTH(CW), .TID(2), .TDATA_WIDTH(TDW), .TDEST_WIDTH(DW),
        .TID_WIDTH(IW), .NUM_ROUTERS(NR), .INJ_RATE(0)
    ) u_dut_zero (
        .clk(clk), .rst_n(rst_n), .ticks(ticks), .enable(z_enable),
        .num_packets(z_num), .sent_packets(z_sent),
        .total_sent_packets(z_total), .done(z_done), .stall_cycles(z_stall),
        .axis_out_tvalid(z_tvalid), .axis_out_tready(z_tready),
        .axis_out_tdata(z_tdata), .axis_out_tlast(z_tlast),
        .axis_out_tid(z_tid), .axis_out_tdest(z_tdest)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0; enable = 1'b0; tready = 1'b0; num_packets = '0;
        z_enable = 1'b0; z_tready = 1'b0; z_num = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        int sum;
        reset_dut();
        sum = 0;
        foreach (sent[d]) sum += int'(sent[d]);
        n_checks++; if (tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %0b want 0", tvalid); end
        n_checks++; if (tlast !== 1'b1) begin n_bad++; $display("FAIL reset_tlast: got %0b want 1", tlast); end
        n_checks++; if (tdata !== '0) begin n_bad++; $display("FAIL reset_tdata: got %h want 0", tdata); end
        n_checks++; if (tdest !== '0 || tid !== '0) begin n_bad++; $display("FAIL reset_tdest_tid: got %0d/%0d want 0/0", tdest, tid); end
        n_checks++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
        n_checks++; if (total_sent !== '0 || sum != 0) begin n_bad++; $display("FAIL reset_counts: got total=%0d sum=%0d want 0/0", total_sent, sum); end
        n_checks++; if (stall !== '0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", stall); end
        n_checks++; if (z_tvalid !== 1'b0 || z_tlast !== 1'b1 || z_tdata !== '0) begin n_bad++; $display("FAIL reset_zero_dut: got v=%0b l=%0b d=%h want 0/1/0", z_tvalid, z_tlast, z_tdata); end
    endtask

    task automatic test_burst();
        int beats, first_cyc, prev_tick, sum;
        int exp_seq [NR];
        beats = 0; first_cyc = -1; prev_tick = 0;
        foreach (exp_seq[d]) exp_seq[d] = 0;
        reset_dut();
        num_packets = 10; enable = 1'b1; tready = 1'b1;
        for (int i = 0; i < 10; i++) q.push_back(i);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (tvalid && tready) begin
                int idx, t, ed, sq;
                idx = (q.size() > 0) ? q.pop_front() : -1;
                t   = int'(tdata[TDW-1:HW]);
                ed  = int'(lfsr_tab[t % 8192][15:8]) % NR;
                sq  = int'(tdata[CW-1:0]);
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    n_checks++; if (t != 1) begin n_bad++; $display("FAIL burst_first_tick: got %0d want 1", t); end
                end else begin
                    n_checks++; if (t != prev_tick + 1) begin n_bad++; $display("FAIL burst_tick_step: got %0d want %0d", t, prev_tick + 1); end
                end
                n_checks++; if (cyc != first_cyc + beats) begin n_bad++; $display("FAIL burst_consecutive: got cycle %0d want %0d", cyc, first_cyc + beats); end
                n_checks++; if (int'(total_sent) != idx) begin n_bad++; $display("FAIL burst_order: got total=%0d want %0d", total_sent, idx); end
                n_checks++; if (int'(tdest) != ed) begin n_bad++; $display("FAIL burst_dest: got %0d want %0d", tdest, ed); end
                n_checks++; if (sq != exp_seq[tdest]) begin n_bad++; $display("FAIL burst_seq: got %0d want %0d", sq, exp_seq[tdest]); end
                n_checks++; if (tlast !== 1'b1 || tid !== IW'(MY_TID)) begin n_bad++; $display("FAIL burst_tlast_tid: got %0b/%0d want 1/%0d", tlast, tid, MY_TID); end
                n_checks++; if (tdata[HW-1:CW] !== '0) begin n_bad++; $display("FAIL burst_pad: got %h want 0", tdata[HW-1:CW]); end
                exp_seq[tdest]++;
                prev_tick = t;
                beats++;
            end
        end
        sum = 0;
        foreach (sent[d]) sum += int'(sent[d]);
        n_checks++; if (done !== 1'b1) begin n_bad++; $display("FAIL burst_done: got %0b want 1", done); end
        n_checks++; if (beats != 10 || q.size() != 0) begin n_bad++; $display("FAIL burst_beats: got %0d left=%0d want 10/0", beats, q.size()); end
        n_checks++; if (total_sent !== CW'(10) || sum != 10) begin n_bad++; $display("FAIL burst_counts: got total=%0d sum=%0d want 10/10", total_sent, sum); end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (done !== 1'b0 || total_sent !== CW'(10)) begin n_bad++; $display("FAIL burst_idle_retain: got done=%0b total=%0d want 0/10", done, total_sent); end
    endtask

    task automatic test_stall();
        logic [TDW-1:0] held_data;
        logic [DW-1:0]  held_dest;
        int beats, exp_stall;
        reset_dut();
        num_packets = 3; enable = 1'b1; tready = 1'b0;
        for (int c = 0; c < 20 && !tvalid; c++) @(negedge clk);
        n_checks++; if (tvalid !== 1'b1) begin n_bad++; $display("FAIL stall_wait_valid: got %0b want 1", tvalid); end
        held_data = tdata; held_dest = tdest;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++; if (tvalid !== 1'b1 || tdata !== held_data || tdest !== held_dest) begin
                n_bad++; $display("FAIL stall_hold: got v=%0b d=%h t=%0d want 1/%h/%0d", tvalid, tdata, tdest, held_data, held_dest);
            end
        end
        @(negedge clk);
`ifdef AXIS_GEN_STALL_COUNT_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        n_checks++; if (int'(stall) != exp_stall) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", stall, exp_stall); end
        n_checks++; if (tdata !== held_data) begin n_bad++; $display("FAIL stall_release_data: got %h want %h", tdata, held_data); end
        tready = 1'b1;
        beats = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (tvalid && tready) beats++;
            @(negedge clk);
        end
        n_checks++; if (beats != 3 || done !== 1'b1 || total_sent !== CW'(3)) begin n_bad++; $display("FAIL stall_drain: got beats=%0d done=%0b total=%0d want 3/1/3", beats, done, total_sent); end
        n_checks++; if (int'(stall) != exp_stall) begin n_bad++; $display("FAIL stall_final: got %0d want %0d", stall, exp_stall); end
    endtask

    task automatic test_zero_packets();
        int seen;
        reset_dut();
        num_packets = '0; enable = 1'b1; tready = 1'b1;
        seen = 0;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %0b want 1", done); end
        for (int c = 0; c < 10; c++) begin
            if (tvalid) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen != 0 || total_sent !== '0) begin n_bad++; $display("FAIL zero_no_beats: got beats=%0d total=%0d want 0/0", seen, total_sent); end
    endtask

    task automatic test_ordering();
        int exp_seq [NR];
        int cnt [NR];
        int beats;
        foreach (exp_seq[d]) begin exp_seq[d] = 0; cnt[d] = 0; end
        beats = 0;
        reset_dut();
        num_packets = 1000; enable = 1'b1;
        for (int i = 0; i < 1000; i++) q.push_back(i);
        for (int c = 0; c < 6000 && !done; c++) begin
            @(negedge clk);
            tready = ($urandom_range(0, 3) != 0);
            if (tvalid && tready) begin
                int idx, t, ed, sq;
                idx = (q.size() > 0) ? q.pop_front() : -1;
                t   = int'(tdata[TDW-1:HW]);
                ed  = int'(lfsr_tab[t % 8192][15:8]) % NR;
                sq  = int'(tdata[CW-1:0]);
                n_checks++; if (int'(tdest) >= NR || int'(tdest) != ed || t >= 8192) begin n_bad++; $display("FAIL order_dest: got %0d want %0d (tick %0d)", tdest, ed, t); end
                n_checks++; if (sq != exp_seq[tdest]) begin n_bad++; $display("FAIL order_seq: dest %0d got %0d want %0d", tdest, sq, exp_seq[tdest]); end
                n_checks++; if (int'(total_sent) != idx) begin n_bad++; $display("FAIL order_total: got %0d want %0d", total_sent, idx); end
                exp_seq[tdest] = (exp_seq[tdest] + 1) % (1 << CW);
                cnt[tdest]++;
                beats++;
            end
        end
        n_checks++; if (done !== 1'b1 || beats != 1000 || q.size() != 0) begin n_bad++; $display("FAIL order_done: got done=%0b beats=%0d left=%0d want 1/1000/0", done, beats, q.size()); end
        n_checks++; if (total_sent !== CW'(1000)) begin n_bad++; $display("FAIL order_total_final: got %0d want 1000", total_sent); end
        for (int d = 0; d < NR; d++) begin
            n_checks++; if (cnt[d] < 190 || cnt[d] > 310) begin n_bad++; $display("FAIL order_balance: dest %0d got %0d want 190..310", d, cnt[d]); end
            n_checks++; if (int'(sent[d]) != cnt[d]) begin n_bad++; $display("FAIL order_sent: dest %0d got %0d want %0d", d, sent[d], cnt[d]); end
        end
        tready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int sum;
        reset_dut();
        num_packets = 50; enable = 1'b1; tready = 1'b1;
        repeat (6) @(negedge clk);
        tready = 1'b0;
        @(negedge clk);
        n_checks++; if (tvalid !== 1'b1 || total_sent === '0) begin n_bad++; $display("FAIL rstmid_pre: got v=%0b total=%0d want 1/nonzero", tvalid, total_sent); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (tvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_async_tvalid: got %0b want 0", tvalid); end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sum = 0;
        foreach (sent[d]) sum += int'(sent[d]);
        n_checks++; if (total_sent !== '0 || sum != 0 || stall !== '0 || done !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_counters: got total=%0d sum=%0d stall=%0d done=%0b want 0/0/0/0", total_sent, sum, stall, done);
        end
        n_checks++; if (tvalid !== 1'b0 || tdata !== '0) begin n_bad++; $display("FAIL rstmid_outputs: got v=%0b d=%h want 0/0", tvalid, tdata); end
    endtask

    task automatic test_enable_drop();
        int beats, z_seen, z_sum;
        reset_dut();
        num_packets = 20; enable = 1'b1; tready = 1'b0;
        z_num = 5; z_enable = 1'b1; z_tready = 1'b1;
        for (int c = 0; c < 20 && !tvalid; c++) @(negedge clk);
        n_checks++; if (tvalid !== 1'b1) begin n_bad++; $display("FAIL drop_wait_valid: got %0b want 1", tvalid); end
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (tvalid !== 1'b1) begin n_bad++; $display("FAIL drop_hold: got %0b want 1", tvalid); end
        end
        tready = 1'b1;
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            if (tvalid && tready) beats++;
            @(negedge clk);
        end
        n_checks++; if (beats != 1) begin n_bad++; $display("FAIL drop_one_beat: got %0d want 1", beats); end
        n_checks++; if (tvalid !== 1'b0 || total_sent !== CW'(1) || done !== 1'b0) begin n_bad++; $display("FAIL drop_idle: got v=%0b total=%0d done=%0b want 0/1/0", tvalid, total_sent, done); end
        z_seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (z_tvalid) z_seen++;
            @(negedge clk);
        end
        z_sum = 0;
        foreach (z_sent[d]) z_sum += int'(z_sent[d]);
        n_checks++; if (z_seen != 0 || z_total !== '0 || z_sum != 0) begin n_bad++; $display("FAIL rate0_beats: got seen=%0d total=%0d sum=%0d want 0/0/0", z_seen, z_total, z_sum); end
        n_checks++; if (z_done !== 1'b0 || z_stall !== '0 || z_tid !== '0 || z_tdest !== '0) begin n_bad++; $display("FAIL rate0_state: got done=%0b stall=%0d tid=%0d dest=%0d want 0/0/0/0", z_done, z_stall, z_tid, z_tdest); end
    endtask

    initial begin
        lfsr_tab[0] = MY_SEED;
        for (int i = 1; i < 8192; i++) lfsr_tab[i] = lfsr_next(lfsr_tab[i-1]);
        test_reset();
        test_burst();
        test_stall();
        test_zero_packets();
        test_ordering();
        test_reset_mid();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
